// File: rtl/mul8u_share_arb.sv
// mul8u_share_arb
//
// Shares one external combinational 8x8 unsigned multiplier among NREQ
// requesters. Requests are granted round-robin, one per cycle. Operands are
// registered into op_a/op_b, which drive the multiplier directly. The product
// comes back on mul_o and is captured into a per-requester result slot one
// cycle later. Each requester may have only one transaction in flight. Its
// pending bit stays set until the result is taken, so a slot is never
// overwritten.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  [NREQ]      request valid per requester
//   req_ready  [NREQ]      one-hot (or zero) grant, combinational
//   req_a      [8*NREQ]    operand A, requester i at [8i+7:8i]
//   req_b      [8*NREQ]    operand B, same packing
//   mul_a      [8]         operand A to the external multiplier (registered)
//   mul_b      [8]         operand B to the external multiplier (registered)
//   mul_o      [16]        product from the external multiplier
//   rsp_valid  [NREQ]      result held for requester i
//   rsp_ready  [NREQ]      requester i takes its result
//   rsp_data   [16*NREQ]   result for requester i at [16i+15:16i]
//   busy                   any transaction pending
//   issue_cnt  [16]        accepted requests since reset, wraps

module mul8u_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    input  logic [15:0]          mul_o,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [16*NREQ-1:0]   rsp_data,
    output logic                 busy,
    output logic [15:0]          issue_cnt
);

    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] gnt_onehot;
    logic [NREQ-1:0] res_onehot;
    logic [NREQ-1:0] rsp_fire;
    logic [IDW-1:0]  last_gnt;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  op_id;
    logic            gnt_found;
    logic            s1_valid;
    logic [7:0]      op_a;
    logic [7:0]      op_b;
    logic [7:0]      sel_a;
    logic [7:0]      sel_b;

    // Round-robin search: first look at indices above last_gnt, then wrap
    // around to indices at or below it. This is the same as starting at
    // last_gnt+1 modulo NREQ, without needing a modulo for non-power-of-two
    // NREQ. The grant is suppressed while rst is high.
    always_comb begin
        eligible   = req_valid & ~pending;
        gnt_found  = 1'b0;
        gnt_idx    = '0;
        sel_a      = '0;
        sel_b      = '0;
        gnt_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found && eligible[i] && (i > int'(last_gnt))) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(i);
                sel_a     = req_a[8*i +: 8];
                sel_b     = req_b[8*i +: 8];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found && eligible[i] && (i <= int'(last_gnt))) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(i);
                sel_a     = req_a[8*i +: 8];
                sel_b     = req_b[8*i +: 8];
            end
        end
        if (rst) begin
            gnt_found = 1'b0;
        end
        if (gnt_found) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

    // Result slot being written this cycle, and responses being taken.
    always_comb begin
        res_onehot = '0;
        if (s1_valid) begin
            res_onehot[op_id] = 1'b1;
        end
        rsp_fire = rsp_valid & rsp_ready;
    end

    assign req_ready = gnt_onehot;
    assign mul_a     = op_a;
    assign mul_b     = op_b;
    assign busy      = |pending;

    // Issue stage registers operands of the granted requester. The result
    // stage captures the product into that requester's slot one cycle later.
    // A handshake and a new grant never hit the same index in one cycle,
    // because a granted requester cannot have a pending transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            s1_valid  <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            last_gnt  <= IDW'(NREQ-1);
            issue_cnt <= '0;
        end else begin
            s1_valid <= gnt_found;
            if (gnt_found) begin
                op_a      <= sel_a;
                op_b      <= sel_b;
                op_id     <= gnt_idx;
                last_gnt  <= gnt_idx;
                issue_cnt <= issue_cnt + 16'd1;
            end
            pending   <= (pending & ~rsp_fire) | gnt_onehot;
            rsp_valid <= (rsp_valid & ~rsp_fire) | res_onehot;
            for (int i = 0; i < NREQ; i++) begin
                if (res_onehot[i]) begin
                    rsp_data[16*i +: 16] <= mul_o;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul8u_share_arb.sv
// Testbench for mul8u_share_arb. It models the external multiplier with
// either an exact product or an approximate stand-in that clears the low six
// product bits. Inputs are driven just after the falling edge. Outputs are
// sampled 1 ns later, well away from the rising edge.

module tb_mul8u_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [8*NREQ-1:0]   req_a = '0;
    logic [8*NREQ-1:0]   req_b = '0;
    logic [7:0]          mul_a;
    logic [7:0]          mul_b;
    logic [15:0]         mul_o;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready = '0;
    logic [16*NREQ-1:0]  rsp_data;
    logic                busy;
    logic [15:0]         issue_cnt;
    logic                approx_mode = 1'b0;

    int checks = 0;
    int errors = 0;

    // Approximate mode clears the low six product bits, so the result is
    // visibly different from the exact product.
    assign mul_o = approx_mode ? ((16'(mul_a) * 16'(mul_b)) & 16'hFFC0)
                               : (16'(mul_a) * 16'(mul_b));

    always #5 clk = ~clk;

    mul8u_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_o     (mul_o),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .issue_cnt (issue_cnt)
    );

    // Global watchdog.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (issue_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_issue_cnt: got %0d expected 0", issue_cnt); end
        checks++; if ({mul_a, mul_b} !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mul_ops: got %h expected 0000", {mul_a, mul_b}); end
        checks++; if (rsp_data !== '0) begin errors++; $display("[TB] FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        set_ops(2, 8'd3, 8'd5);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL single_ready: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++; if (mul_a !== 8'd3 || mul_b !== 8'd5) begin errors++; $display("[TB] FAIL single_mul_ops: got %0d,%0d expected 3,5", mul_a, mul_b); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL single_early_valid: got %b expected 0000", rsp_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
        checks++; if (issue_cnt !== 16'd1) begin errors++; $display("[TB] FAIL single_issue_cnt: got %0d expected 1", issue_cnt); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("[TB] FAIL single_rsp_valid: got %b expected 0100", rsp_valid); end
        checks++; if (rsp_data[47:32] !== 16'd15) begin errors++; $display("[TB] FAIL single_rsp_data: got %0d expected 15", rsp_data[47:32]); end
        rsp_ready = 4'b0100;
        @(negedge clk);
        rsp_ready = '0;
        #1;
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL single_rsp_cleared: got %b expected 0000", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got %b expected 0", busy); end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_rdy;
        logic [3:0] exp_rv;
        int j;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i + 1), 8'd10);
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % 4);
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("[TB] FAIL rot_ready[%0d]: got %b expected %b", k, req_ready, exp_rdy); end
            checks++; if (issue_cnt !== 16'(k)) begin errors++; $display("[TB] FAIL rot_issue_cnt[%0d]: got %0d expected %0d", k, issue_cnt, k); end
            if (k >= 2) begin
                j = (k - 2) % 4;
                exp_rv = 4'b0001 << j;
                checks++; if (rsp_valid !== exp_rv) begin errors++; $display("[TB] FAIL rot_rsp_valid[%0d]: got %b expected %b", k, rsp_valid, exp_rv); end
                checks++; if (rsp_data[16*j +: 16] !== 16'((j + 1) * 10)) begin errors++; $display("[TB] FAIL rot_rsp_data[%0d]: got %0d expected %0d", k, rsp_data[16*j +: 16], (j + 1) * 10); end
            end else begin
                checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL rot_rsp_valid[%0d]: got %b expected 0000", k, rsp_valid); end
            end
            @(negedge clk);
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rot_drain_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_pressure();
        int exp_g [12] = '{0, 1, 2, 3, 0, 2, 3, 0, 2, 3, 0, 2};
        logic [3:0] exp_rdy;
        do_reset();
        set_ops(0, 8'd2, 8'd2);
        set_ops(1, 8'd255, 8'd255);
        set_ops(2, 8'd4, 8'd4);
        set_ops(3, 8'd6, 8'd6);
        req_valid = 4'hF;
        rsp_ready = 4'b1101;
        for (int k = 0; k < 12; k++) begin
            #1;
            exp_rdy = 4'b0001 << exp_g[k];
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("[TB] FAIL bp_ready[%0d]: got %b expected %b", k, req_ready, exp_rdy); end
            if (k >= 3) begin
                checks++; if (rsp_valid[1] !== 1'b1 || rsp_data[31:16] !== 16'hFE01) begin errors++; $display("[TB] FAIL bp_hold[%0d]: got valid %b data %h expected 1 fe01", k, rsp_valid[1], rsp_data[31:16]); end
            end
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 4'hF;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL bp_drain: got busy %b valid %b expected 0 0000", busy, rsp_valid); end
        checks++; if (rsp_data[31:16] !== 16'hFE01) begin errors++; $display("[TB] FAIL bp_data_kept: got %h expected fe01", rsp_data[31:16]); end
    endtask

    task automatic test_approx();
        do_reset();
        approx_mode = 1'b1;
        set_ops(3, 8'd200, 8'd100);
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid[3] !== 1'b1 || rsp_data[63:48] !== 16'h4E00) begin errors++; $display("[TB] FAIL approx_product: got valid %b data %h expected 1 4e00", rsp_valid[3], rsp_data[63:48]); end
        rsp_ready = 4'b1000;
        @(negedge clk);
        rsp_ready = '0;
        approx_mode = 1'b0;
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL approx_reissue_ready: got %b expected 1000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid[3] !== 1'b1 || rsp_data[63:48] !== 16'd20000) begin errors++; $display("[TB] FAIL exact_product: got valid %b data %0d expected 1 20000", rsp_valid[3], rsp_data[63:48]); end
        rsp_ready = 4'b1000;
        @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_ops(0, 8'd7, 8'd7);
        set_ops(1, 8'd9, 8'd9);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = 4'hF;
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL mid_ready_in_reset: got %b expected 0000", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0 || issue_cnt !== 16'd0) begin errors++; $display("[TB] FAIL mid_cleared: got valid %b busy %b cnt %0d expected 0000 0 0", rsp_valid, busy, issue_cnt); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL mid_first_grant: got %b expected 0001", req_ready); end
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL mid_no_stale_result: got %b expected 0000", rsp_valid); end
        rsp_ready = 4'hF;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i + 3), 8'd2);
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        for (int k = 0; k < 65535; k++) @(negedge clk);
        #1;
        checks++; if (issue_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_max: got %h expected ffff", issue_cnt); end
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL wrap_ready_before: got %b expected 1000", req_ready); end
        @(negedge clk);
        #1;
        checks++; if (issue_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_zero: got %h expected 0000", issue_cnt); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL wrap_ready_after: got %b expected 0001", req_ready); end
        checks++; if (rsp_valid !== 4'b0100 || rsp_data[47:32] !== 16'd10) begin errors++; $display("[TB] FAIL wrap_rsp: got valid %b data %0d expected 0100 10", rsp_valid, rsp_data[47:32]); end
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        $display("[TB] starting mul8u_share_arb tests");
        test_reset();
        test_single();
        test_rotation();
        test_back_pressure();
        test_approx();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul8u_share_arb.md
# mul8u_share_arb

Shares one combinational 8x8 unsigned multiplier (any of the mul8u_* approximate variants) among NREQ requesters. Per-requester valid/ready request and response channels; round-robin grant; one issue per cycle. The multiplier sits outside the block, wired to mul_a/mul_b/mul_o, so variants can be swapped without touching the controller.

## Interface
- NREQ, 4: number of requesters (2..8).
- IDW, 2: grant index width, equal to ceil(log2(NREQ)); min 1.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  request accepted this cycle; one-hot or zero.
- req_a  in  8*NREQ  operand A; requester i uses bits [8i+7:8i].
- req_b  in  8*NREQ  operand B; same packing as req_a.
- mul_a  out  8  operand A to the external multiplier.
- mul_b  out  8  operand B to the external multiplier.
- mul_o  in  16  product from the external multiplier, combinational from mul_a/mul_b.
- rsp_valid  out  NREQ  result held for requester i.
- rsp_ready  in  NREQ  requester i takes its result.
- rsp_data  out  16*NREQ  result for requester i at bits [16i+15:16i].
- busy  out  1  OR of all pending bits.
- issue_cnt  out  16  number of accepted requests since reset; wraps modulo 2^16.

## Operation
- Each requester i has a pending[i] bit.
  - Set when its request is accepted.
  - Cleared on the rising edge where rsp_valid[i] & rsp_ready[i].
- Eligibility: eligible[i] = req_valid[i] & ~pending[i]. A requester has at most one transaction in flight.
- Arbitration is round-robin.
  - last_gnt (IDW bits) records the most recent grant.
  - The search starts at last_gnt+1 modulo NREQ and takes the first eligible index g.
  - req_ready[g] = 1 combinationally in the same cycle; every other req_ready bit is 0. If nothing is eligible, req_ready = 0.
  - req_ready depends only on req_valid and registered state, never on rsp_ready.
- Accept edge (some bit of req_valid & req_ready is 1):
  - op_a <= req_a[g], op_b <= req_b[g], op_id <= g, s1_valid <= 1.
  - last_gnt <= g, pending[g] <= 1, issue_cnt <= issue_cnt + 1.
  - With no accept: s1_valid <= 0 and last_gnt holds.
- mul_a = op_a and mul_b = op_b, driven straight from registers. Registers hold their value when idle; no glitching from arbitration.
- Result edge: when s1_valid = 1, rsp_data[op_id] <= mul_o and rsp_valid[op_id] <= 1.
- A result register holds its data until its handshake, then rsp_valid[i] <= 0. rsp_data[i] keeps its last value.
- Because pending[op_id] stays 1 until the handshake, a response slot is never overwritten.
- The product is passed through unmodified, 16 bits, with no rounding or saturation; any approximation error is the multiplier's.

## Timing
- Reset values, applied on a clk edge while rst = 1:
  - pending, rsp_valid, s1_valid, op_a, op_b, op_id, rsp_data, issue_cnt all 0.
  - last_gnt = NREQ-1, so requester 0 wins first.
  - req_ready is 0 during reset cycles.
- Latency: accept at edge t gives rsp_valid high in the cycle after edge t+1, i.e. 2 cycles after the accept edge.
- Throughput is one accept per cycle across requesters. When all requesters stream, grants rotate 0,1,2,3,0,...
- Same-requester rate: if the response handshakes on the first cycle it is valid (edge t+2), the requester is re-eligible in the following cycle. Minimum spacing is 3 cycles.
- A response handshake and a new grant to a different requester in the same cycle are independent and both take effect.
- A result write and a response handshake can fall on the same edge only for different indices; same index is impossible by construction.
- req_valid dropped without req_ready: no state change. Requesters must not change operands while valid and not ready; this is a bench protocol check.
- rst asserted mid-operation discards in-flight and held results. issue_cnt goes to 0 and rsp_valid drops on the reset edge.
- issue_cnt goes 0xFFFF -> 0x0000 on the next accept.

## Test plan
- Reset then single request: requester 2, A=3, B=5, bench mul_o = exact product. req_ready[2] is high in the same cycle. mul_a=3 and mul_b=5 one cycle later. rsp_valid[2] with rsp_data=15 two cycles after accept. issue_cnt=1.
- All four valid continuously, rsp_ready=1: accepts in order 0,1,2,3. Each of those responses is valid 2 cycles after its accept. Requester 0 is re-granted at the earliest 3 cycles after its first accept.
- Backpressure: requester 1 with rsp_ready=0 for 10 cycles, A=B=255. rsp_data[1]=0xFE01 holds stable. Requester 1 gets no further req_ready while pending. Requesters 0, 2 and 3 are still served in rotation.
- Approximate multiplier attached with A=200, B=100: rsp_data equals mul8u_197B output for those operands. Same operands through a mul8u_* exact variant give 20000.
- Reset mid-flight: assert rst the cycle after an accept. rsp_valid, busy and issue_cnt are all 0 after the edge. Requester 0 wins the first grant after rst deasserts.
- Wrap: preload the count with 65536 accepts (or force the counter). issue_cnt reads 0x0000 and all other behaviour is unchanged.
